atm_pin_sender: RTL and testbench

Card-side transmitter for the ATM PIN protocol (`cartao`, `cod`, `entra` in; `dinheiro`, `destroi` out of the ATM). On `start` it inserts the card, sends a latched 3-digit PIN one digit per `entra` pulse, then waits for the ATM verdict. If no verdict arrives, it retries up to `MAX_TRIES` times. It sits beside the ATM FSM in `top`, driven from switches, and lets the bench or board run a full transaction from a single request.

---
 rtl/atm_pin_sender_if.sv | 13 +
 rtl/atm_pin_sender.sv | 164 ++++++++++++++++
 tb/tb_atm_pin_sender.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pin_sender_if.sv
// ATM-side bus of the PIN sender: card/digit signals toward the ATM, verdict back.
interface atm_pin_sender_if #(
    parameter int unsigned DIGIT_BITS = 3
);
    logic                  cartao;
    logic                  entra;
    logic [DIGIT_BITS-1:0] cod;
    logic                  dinheiro;
    logic                  destroi;

    modport master (output cartao, output entra, output cod, input dinheiro, input destroi);
    modport slave  (input cartao, input entra, input cod, output dinheiro, output destroi);
endinterface

// File: rtl/atm_pin_sender.sv
// Card-side transmitter: inserts the card, sends a latched 3-digit PIN and waits
// for the ATM verdict, retrying up to MAX_TRIES times on a silent ATM.
module atm_pin_sender #(
    parameter int unsigned DIGIT_BITS  = 3,
    parameter int unsigned RESP_CYCLES = 8,
    parameter int unsigned MAX_TRIES   = 3
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIGIT_BITS-1:0] pin1,
    input  logic [DIGIT_BITS-1:0] pin2,
    input  logic [DIGIT_BITS-1:0] pin3,
    atm_pin_sender_if.master      atm,
    output logic                  busy,
    output logic                  ok,
    output logic                  fail,
    output logic                  destroyed,
    output logic                  pin_err,
    output logic [1:0]            tries
);
    localparam int unsigned     CW       = (RESP_CYCLES > 1) ? $clog2(RESP_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(RESP_CYCLES - 1);
    localparam logic [1:0]      TRY_MAX  = 2'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, CARD, SEND, GAP, WAIT, DONE_OK, DONE_FAIL} state_t;

    state_t                state, state_n;
    logic [1:0]            idx_q, idx_n;
    logic [1:0]            tries_q, tries_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  destroyed_q, destroyed_n;
    logic                  pin_err_q, pin_err_n;
    logic                  load_pins;
    logic [DIGIT_BITS-1:0] pin_q1, pin_q2, pin_q3;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx_q       <= '0;
            tries_q     <= '0;
            cnt_q       <= '0;
            destroyed_q <= 1'b0;
            pin_err_q   <= 1'b0;
            pin_q1      <= '0;
            pin_q2      <= '0;
            pin_q3      <= '0;
        end else begin
            state       <= state_n;
            idx_q       <= idx_n;
            tries_q     <= tries_n;
            cnt_q       <= cnt_n;
            destroyed_q <= destroyed_n;
            pin_err_q   <= pin_err_n;
            if (load_pins) begin
                pin_q1 <= pin1;
                pin_q2 <= pin2;
                pin_q3 <= pin3;
            end
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx_q;
        tries_n     = tries_q;
        cnt_n       = cnt_q;
        destroyed_n = destroyed_q;
        pin_err_n   = pin_err_q;
        load_pins   = 1'b0;
        case (state)
            IDLE: begin
                idx_n       = '0;
                tries_n     = '0;
                destroyed_n = 1'b0;
                pin_err_n   = 1'b0;
                if (start) begin
                    load_pins = 1'b1;
                    // A zero digit can never be sent, so the card is never inserted.
                    if (pin1 == '0 || pin2 == '0 || pin3 == '0) begin
                        state_n   = DONE_FAIL;
                        pin_err_n = 1'b1;
                    end else begin
                        state_n = CARD;
                    end
                end
            end
            CARD: begin
                if (tries_q != TRY_MAX) tries_n = tries_q + 2'd1;
                idx_n   = '0;
                state_n = GAP;
            end
            GAP: begin
                if (idx_q < 2'd3) begin
                    state_n = SEND;
                end else begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                idx_n   = idx_q + 2'd1;
                state_n = GAP;
            end
            WAIT: begin
                if (atm.destroi) begin
                    state_n     = DONE_FAIL;
                    destroyed_n = 1'b1;
                end else if (atm.dinheiro) begin
                    state_n = DONE_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = (tries_q == TRY_MAX) ? DONE_FAIL : CARD;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE_OK, DONE_FAIL: begin
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        atm.cartao = 1'b0;
        atm.entra  = 1'b0;
        atm.cod    = '0;
        busy       = 1'b0;
        ok         = 1'b0;
        fail       = 1'b0;
        destroyed  = 1'b0;
        pin_err    = 1'b0;
        tries      = '0;
        case (state)
            CARD, GAP, WAIT: begin
                atm.cartao = 1'b1;
                busy       = 1'b1;
                tries      = tries_q;
            end
            SEND: begin
                atm.cartao = 1'b1;
                atm.entra  = 1'b1;
                busy       = 1'b1;
                tries      = tries_q;
                case (idx_q)
                    2'd0:    atm.cod = pin_q1;
                    2'd1:    atm.cod = pin_q2;
                    default: atm.cod = pin_q3;
                endcase
            end
            DONE_OK: begin
                ok    = 1'b1;
                tries = tries_q;
            end
            DONE_FAIL: begin
                fail      = 1'b1;
                destroyed = destroyed_q;
                pin_err   = pin_err_q;
                tries     = tries_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_atm_pin_sender.sv
// Bench for atm_pin_sender: a timeline model of each transaction, checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_atm_pin_sender;
    localparam int DB = 3, R = 8, MAXT = 3, L = 8 + R;

    logic          clk_2 = 1'b0, reset = 1'b1, start = 1'b0;
    logic [DB-1:0] pin1 = '0, pin2 = '0, pin3 = '0;
    logic          busy, ok, fail, destroyed, pin_err;
    logic [1:0]    tries;

    atm_pin_sender_if #(.DIGIT_BITS(DB)) bus();

    atm_pin_sender #(.DIGIT_BITS(DB), .RESP_CYCLES(R), .MAX_TRIES(MAXT)) dut (
        .clk_2(clk_2), .reset(reset), .start(start),
        .pin1(pin1), .pin2(pin2), .pin3(pin3), .atm(bus),
        .busy(busy), .ok(ok), .fail(fail), .destroyed(destroyed),
        .pin_err(pin_err), .tries(tries)
    );

    initial forever #5 clk_2 = ~clk_2;

    int vectors = 0, miscompares = 0;
    int m_phase = 0, m_r = 0, m_tries = 0, ma, mp, ra, rp;
    bit m_destroyed = 1'b0, m_pin_err = 1'b0;
    logic [DB-1:0] m_pin [3];
    int resp_mode = 0, resp_att = 0, resp_k = 0, cur_j = 0;
    bit noise_en = 1'b0;
    logic [DB-1:0] q1, q2, q3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.cartao, bus.entra, bus.cod, busy, ok, fail, destroyed, pin_err, tries};
    endfunction

    // Expected outputs from phase and cycles elapsed since the start edge.
    function automatic logic [11:0] model_out();
        logic c = 1'b0, e = 1'b0, b = 1'b0, o = 1'b0, f = 1'b0, d = 1'b0, pe = 1'b0;
        logic [DB-1:0] cd = '0;
        logic [1:0] t = '0;
        int a, p;
        case (m_phase)
            1: begin
                a = (m_r - 1) / L;
                p = (m_r - 1) % L + 1;
                c = 1'b1;
                b = 1'b1;
                t = 2'(a + ((p >= 2) ? 1 : 0));
                if (p == 3 || p == 5 || p == 7) begin
                    e  = 1'b1;
                    cd = m_pin[(p - 3) / 2];
                end
            end
            2: begin o = 1'b1; t = 2'(m_tries); end
            3: begin f = 1'b1; d = m_destroyed; pe = m_pin_err; t = 2'(m_tries); end
            default: ;
        endcase
        return {c, e, cd, b, o, f, d, pe, t};
    endfunction

    // Transaction-level reference: phase 0 idle, 1 running, 2 cash, 3 failed.
    initial forever begin
        @(posedge clk_2 or posedge reset);
        if (reset) begin
            m_phase = 0; m_r = 0; m_tries = 0; m_destroyed = 1'b0; m_pin_err = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_pin[0] = pin1; m_pin[1] = pin2; m_pin[2] = pin3;
                    m_tries = 0; m_destroyed = 1'b0; m_pin_err = 1'b0;
                    if (pin1 == 0 || pin2 == 0 || pin3 == 0) begin
                        m_phase = 3; m_pin_err = 1'b1;
                    end else begin
                        m_phase = 1; m_r = 1;
                    end
                end
                1: begin
                    ma = (m_r - 1) / L;
                    mp = (m_r - 1) % L + 1;
                    if (mp >= 9 && bus.destroi) begin
                        m_phase = 3; m_destroyed = 1'b1; m_tries = ma + 1;
                    end else if (mp >= 9 && bus.dinheiro) begin
                        m_phase = 2; m_tries = ma + 1;
                    end else if (mp == L && ma + 1 == MAXT) begin
                        m_phase = 3; m_tries = MAXT;
                    end else begin
                        m_r++;
                    end
                end
                default: if (!start) m_phase = 0;
            endcase
        end
    end

    // ATM stand-in: verdict at the chosen WAIT cycle, optional junk outside WAIT.
    initial forever begin
        @(posedge clk_2);
        #2;
        rp = 0;
        ra = 0;
        if (m_phase == 1) begin
            ra = (m_r - 1) / L;
            rp = (m_r - 1) % L + 1;
        end
        if (rp >= 9) begin
            bus.dinheiro = (resp_mode != 0 && ra == resp_att && rp - 9 == resp_k) ? resp_mode[0] : 1'b0;
            bus.destroi  = (resp_mode != 0 && ra == resp_att && rp - 9 == resp_k) ? resp_mode[1] : 1'b0;
        end else begin
            bus.dinheiro = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.destroi  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial forever begin
        @(negedge clk_2);
        check("outputs", 32'(dut_vec()), 32'(model_out()));
    end

    task automatic next_neg();
        @(negedge clk_2);
        cur_j++;
        if (start && cur_j >= 1) begin
            pin1 = DB'($urandom);
            pin2 = DB'($urandom);
            pin3 = DB'($urandom);
        end
    endtask

    task automatic adv(input int j);
        while (cur_j < j) next_neg();
    endtask

    task automatic start_txn(input logic [DB-1:0] p1, input logic [DB-1:0] p2, input logic [DB-1:0] p3,
                             input int mode, input int att, input int k);
        @(posedge clk_2);
        #1;
        resp_mode = mode; resp_att = att; resp_k = k;
        pin1 = p1; pin2 = p2; pin3 = p3;
        start = 1'b1;
        cur_j = -1;
    endtask

    task automatic finish_txn();
        int n = 0;
        while (!(m_phase == 2 || m_phase == 3) && n < 200) begin
            next_neg();
            n++;
        end
        if (n >= 200) check("done_timeout", 32'd0, 32'd1);
        repeat ($urandom_range(0, 3)) next_neg();
        @(posedge clk_2);
        #1;
        start = 1'b0;
        repeat (2) next_neg();
    endtask

    initial begin
        bus.dinheiro = 1'b0;
        bus.destroi  = 1'b0;
        repeat (3) @(posedge clk_2);
        #1 reset = 1'b0;
        @(negedge clk_2);
        check("reset_state", 32'(dut_vec()), 32'd0);

        // Correct PIN, cash at WAIT cycle 1 of attempt 1.
        start_txn(3'd1, 3'd3, 3'd7, 1, 0, 1);
        adv(1);  check("card_cartao", 32'(bus.cartao), 32'd1);
                 check("card_tries", 32'(tries), 32'd0);
        adv(3);  check("d1", 32'({bus.entra, bus.cod}), 32'({1'b1, 3'd1}));
        adv(4);  check("gap", 32'({bus.entra, bus.cod}), 32'd0);
        adv(5);  check("d2", 32'({bus.entra, bus.cod}), 32'({1'b1, 3'd3}));
        adv(7);  check("d3", 32'({bus.entra, bus.cod}), 32'({1'b1, 3'd7}));
        adv(11); check("cash", 32'({ok, tries, bus.cartao}), 32'({1'b1, 2'd1, 1'b0}));
        finish_txn();

        // Silent ATM: three full attempts then failure.
        start_txn(3'd2, 3'd2, 3'd2, 0, 0, 0);
        adv(35); check("retry3_d1", 32'({bus.entra, bus.cod, tries}), 32'({1'b1, 3'd2, 2'd3}));
        adv(48); check("last_wait", 32'({bus.cartao, fail}), 32'({1'b1, 1'b0}));
        adv(49); check("timeout_fail", 32'({fail, tries, destroyed}), 32'({1'b1, 2'd3, 1'b0}));
        finish_txn();

        // Destroy at 2nd WAIT cycle of attempt 1.
        start_txn(3'd4, 3'd5, 3'd6, 2, 0, 1);
        adv(11); check("destroy", 32'({fail, destroyed, bus.cartao}), 32'({1'b1, 1'b1, 1'b0}));
        finish_txn();

        // Both verdicts together on attempt 2: destroy wins.
        start_txn(3'd7, 3'd1, 3'd2, 3, 1, 3);
        adv(29); check("both", 32'({fail, destroyed, ok, tries}), 32'({1'b1, 1'b1, 1'b0, 2'd2}));
        finish_txn();

        // Zero digit.
        start_txn(3'd1, 3'd0, 3'd7, 0, 0, 0);
        adv(1);  check("pin_err", 32'({fail, pin_err, bus.cartao}), 32'({1'b1, 1'b1, 1'b0}));
        finish_txn();
        check("idle_after_pin_err", 32'(dut_vec()), 32'd0);

        // Reset during SEND d2, then restart with start held.
        start_txn(3'd1, 3'd3, 3'd7, 0, 0, 0);
        adv(5);  check("pre_reset_d2", 32'({bus.entra, bus.cod}), 32'({1'b1, 3'd3}));
        #2 reset = 1'b1;
        #1 check("reset_async", 32'(dut_vec()), 32'd0);
        @(posedge clk_2);
        @(posedge clk_2);
        #1;
        pin1 = 3'd1; pin2 = 3'd3; pin3 = 3'd7;
        reset = 1'b0;
        cur_j = -1;
        adv(1);  check("restart_card", 32'({bus.cartao, busy, tries}), 32'({1'b1, 1'b1, 2'd0}));
        adv(3);  check("restart_d1", 32'({bus.entra, bus.cod}), 32'({1'b1, 3'd1}));
        finish_txn();

        for (int n = 0; n < 30; n++) begin
            q1 = DB'($urandom_range(1, 7));
            q2 = DB'($urandom_range(1, 7));
            q3 = DB'($urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) q2 = '0;
            noise_en = 1'($urandom_range(0, 1));
            start_txn(q1, q2, q3, int'($urandom_range(0, 3)), int'($urandom_range(0, MAXT - 1)),
                      int'($urandom_range(0, R - 1)));
            finish_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
